// File: rtl/arbiter_n_to_1_request_scheduler_if.sv
// rtl/arbiter_n_to_1_request_scheduler_if.sv - packet types and request/response bundle for the N-to-1 scheduler
//
// Purpose: shared packet/FIFO-state types and the interface that groups every
// non-clock, non-reset signal of arbiter_n_to_1_request_scheduler.
// Ports (interface members):
//   enable_in                   scheduling enable (low pauses new grants)
//   request_in[N-1:0]           FWFT heads of the requester FIFOs
//   fifo_downstream_signals_in  downstream FIFO state (prog_full used)
//   fifo_request_signals_out    per-requester rd_en / wr_en
//   request_out                 forwarded packet
//   grant_out                   one-hot registered grant
//   busy_out                    grant or output packet in flight
// master: drives requests/enable/downstream state; slave: the scheduler.

package arbiter_n_to_1_request_scheduler_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] payload;
  } EnginePacket;

  typedef struct packed {
    logic full;
    logic prog_full;
    logic empty;
  } FIFOStateSignalsOutput;

  typedef struct packed {
    logic rd_en;
    logic wr_en;
  } FIFOStateSignalsInput;

endpackage

interface arbiter_n_to_1_request_scheduler_if #(
  parameter int NUM_ENGINE_REQUESTOR = 4
) ();
  import arbiter_n_to_1_request_scheduler_pkg::*;

  logic                                            enable_in;
  EnginePacket          [NUM_ENGINE_REQUESTOR-1:0] request_in;
  FIFOStateSignalsOutput                           fifo_downstream_signals_in;
  FIFOStateSignalsInput [NUM_ENGINE_REQUESTOR-1:0] fifo_request_signals_out;
  EnginePacket                                     request_out;
  logic                 [NUM_ENGINE_REQUESTOR-1:0] grant_out;
  logic                                            busy_out;

  modport master (
    output enable_in, request_in, fifo_downstream_signals_in,
    input  fifo_request_signals_out, request_out, grant_out, busy_out
  );

  modport slave (
    input  enable_in, request_in, fifo_downstream_signals_in,
    output fifo_request_signals_out, request_out, grant_out, busy_out
  );

endinterface

// File: rtl/arbiter_n_to_1_request_scheduler.sv
// rtl/arbiter_n_to_1_request_scheduler.sv - round-robin N-to-1 request scheduler
//
// Purpose: shares one downstream request path among NUM_ENGINE_REQUESTOR
// FWFT requester FIFOs. Grants at most one requester per cycle, pops it with
// rd_en and forwards the popped packet one cycle later.
// Ports:
//   ap_clk  clock
//   areset  synchronous active-high reset, registered once before use
//   bus     slave side of arbiter_n_to_1_request_scheduler_if

module arbiter_n_to_1_request_scheduler
  import arbiter_n_to_1_request_scheduler_pkg::*;
#(
  parameter int NUM_ENGINE_REQUESTOR = 4,
  parameter int REQ_SEL_WIDTH        = $clog2(NUM_ENGINE_REQUESTOR)
) (
  input logic                               ap_clk,
  input logic                               areset,
  arbiter_n_to_1_request_scheduler_if.slave bus
);

  localparam int N = NUM_ENGINE_REQUESTOR;

  typedef enum logic [1:0] {
    S_SETUP,
    S_IDLE,
    S_RUN,
    S_STALL
  } state_t;

  state_t                   state;
  logic                     rst_q;
  logic [REQ_SEL_WIDTH-1:0] rr_ptr;
  logic [REQ_SEL_WIDTH-1:0] rr_ptr_next;
  logic [N-1:0]             rd_en_reg;
  logic [N-1:0]             elig;
  logic [N-1:0]             grant_vec;
  logic                     grant_valid;
  logic                     prog_full;
  logic                     out_valid;
  logic [31:0]              out_payload;
  logic                     unused_fifo_state;

  assign prog_full         = bus.fifo_downstream_signals_in.prog_full;
  assign unused_fifo_state = bus.fifo_downstream_signals_in.full ^
                             bus.fifo_downstream_signals_in.empty;

  always_ff @(posedge ap_clk) begin
    rst_q <= areset;
  end

  // A requester popped this cycle still shows its old FWFT head; mask it.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = bus.request_in[i].valid & ~rd_en_reg[i];
    end
  end

  // First eligible index scanning upward from rr_ptr, modulo N.
  always_comb begin : p_grant
    logic [REQ_SEL_WIDTH-1:0] idx;
    idx         = '0;
    grant_vec   = '0;
    grant_valid = 1'b0;
    rr_ptr_next = rr_ptr;
    if (state == S_RUN && !prog_full) begin
      for (int k = 0; k < N; k++) begin
        idx = REQ_SEL_WIDTH'((int'(rr_ptr) + k) % N);
        if (!grant_valid && elig[idx]) begin
          grant_valid    = 1'b1;
          grant_vec[idx] = 1'b1;
          rr_ptr_next    = REQ_SEL_WIDTH'((int'(idx) + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (rst_q) begin
      state     <= S_SETUP;
      rr_ptr    <= '0;
      rd_en_reg <= '0;
      out_valid <= 1'b0;
    end else begin
      // Raw areset squashes anything in flight so no packet is delivered
      // while the registered reset is still catching up.
      rd_en_reg <= areset ? '0 : grant_vec;
      out_valid <= ~areset & (|rd_en_reg);
      if (grant_valid) begin
        rr_ptr <= rr_ptr_next;
      end
      case (state)
        S_SETUP: state <= S_IDLE;
        S_IDLE:  if (bus.enable_in) state <= S_RUN;
        S_RUN: begin
          if (prog_full)           state <= S_STALL;
          else if (!bus.enable_in) state <= S_IDLE;
        end
        S_STALL: begin
          if (!prog_full) state <= bus.enable_in ? S_RUN : S_IDLE;
        end
        default: state <= S_SETUP;
      endcase
    end
  end

  // Payload is captured while the granted head is still unpopped; it is
  // deliberately not reset and holds when out_valid is low.
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_en_reg[i]) begin
        out_payload <= bus.request_in[i].payload;
      end
    end
  end

  always_comb begin
    bus.fifo_request_signals_out = '0;
    for (int i = 0; i < N; i++) begin
      bus.fifo_request_signals_out[i].rd_en = rd_en_reg[i];
      bus.fifo_request_signals_out[i].wr_en = 1'b0;
    end
  end

  assign bus.request_out = {out_valid, out_payload};
  assign bus.grant_out   = rd_en_reg;
  assign bus.busy_out    = (|rd_en_reg) | out_valid;

endmodule
